branch_target_predictor: RTL

Parametrised branch predictor with a direct-mapped, tagged branch target buffer (BTB) and a per-entry saturating-counter pattern history table (PHT). It gives the fetch stage a same-cycle taken/target prediction. It takes resolved outcomes from execute to train the tables and to raise a registered redirect/flush on mispredict. It sits between the PC-select mux (fetch) and the branch/jump resolution logic (execute).

---
 rtl/bp_pkg.sv | 22 ++
 rtl/bp_sat_counter.sv | 19 +
 rtl/branch_target_predictor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and counter helpers for the branch target predictor
package bp_pkg;

  localparam int BP_DEF_ADDR_W = 32;
  localparam int BP_DEF_IDX_W  = 5;
  localparam int BP_DEF_CTR_W  = 2;

  // Weakly not taken: just below the MSB threshold.
  function automatic int ctr_reset_val(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Weakly taken: the MSB alone.
  function automatic int ctr_alloc_val(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int ctr_max_val(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational CTR_W-bit saturating up/down step
module bp_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] count,
  input  logic             up,
  output logic [CTR_W-1:0] next_count
);

  always_comb begin
    next_count = count;
    if (up) begin
      if (count != {CTR_W{1'b1}}) next_count = count + CTR_W'(1);
    end else begin
      if (count != {CTR_W{1'b0}}) next_count = count - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - tagged direct-mapped BTB + saturating-counter PHT with registered redirect
// Optional BP_GSHARE_EN: PHT indexed by PC index XOR global history.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W = BP_DEF_ADDR_W,
  parameter int IDX_W  = BP_DEF_IDX_W,
  parameter int CTR_W  = BP_DEF_CTR_W,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              f_valid_i,
  input  logic [ADDR_W-1:0] f_pc_i,
  output logic              f_taken_o,
  output logic [ADDR_W-1:0] f_target_o,
  input  logic              r_valid_i,
  input  logic [ADDR_W-1:0] r_pc_i,
  input  logic              r_is_jump_i,
  input  logic              r_taken_i,
  input  logic [ADDR_W-1:0] r_target_i,
  input  logic              r_pred_taken_i,
  input  logic [ADDR_W-1:0] r_pred_target_i,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              flush_o
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'(ctr_reset_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_alloc_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX   = CTR_W'(ctr_max_val(CTR_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } bp_entry_t;

  bp_entry_t        btb_q [ENTRIES];
  logic [CTR_W-1:0] pht_q [ENTRIES];

  logic [IDX_W-1:0]  f_idx, f_pidx, r_idx, r_pidx;
  logic [TAG_W-1:0]  f_tag, r_tag;
  logic [ADDR_W-1:0] f_seq_pc, r_seq_pc;
  logic [ADDR_W-1:0] actual_next, pred_next;
  logic [CTR_W-1:0]  ctr_next;
  bp_entry_t         f_entry;
  logic              f_hit, r_hit, r_dir, mispredict;

  assign f_idx = f_pc_i[IDX_W+1:2];
  assign f_tag = f_pc_i[ADDR_W-1:IDX_W+2];
  assign r_idx = r_pc_i[IDX_W+1:2];
  assign r_tag = r_pc_i[ADDR_W-1:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  // Jumps carry no direction information, so they leave the history alone.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ghr_q <= '0;
    end else if (r_valid_i && !r_is_jump_i) begin
      ghr_q <= IDX_W'({ghr_q, r_taken_i});
    end
  end

  assign f_pidx = f_idx ^ ghr_q;
  assign r_pidx = r_idx ^ ghr_q;
`else
  assign f_pidx = f_idx;
  assign r_pidx = r_idx;
`endif

  assign f_entry    = btb_q[f_idx];
  assign f_hit      = f_entry.valid && (f_entry.tag == f_tag);
  assign f_seq_pc   = f_pc_i + ADDR_W'(4);
  assign f_taken_o  = f_valid_i && f_hit && pht_q[f_pidx][CTR_W-1];
  assign f_target_o = f_taken_o ? f_entry.target : f_seq_pc;

  assign r_hit       = btb_q[r_idx].valid && (btb_q[r_idx].tag == r_tag);
  assign r_dir       = r_taken_i || r_is_jump_i;
  assign r_seq_pc    = r_pc_i + ADDR_W'(4);
  assign actual_next = r_dir ? r_target_i : r_seq_pc;
  assign pred_next   = r_pred_taken_i ? r_pred_target_i : r_seq_pc;
  assign mispredict  = r_valid_i && (actual_next != pred_next);

  bp_sat_counter #(
    .CTR_W(CTR_W)
  ) u_upd_ctr (
    .count     (pht_q[r_pidx]),
    .up        (r_dir),
    .next_count(ctr_next)
  );

  // Lookups read these arrays combinationally, so a same-cycle update is seen only after the edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
        pht_q[i] <= CTR_RST;
      end
    end else if (r_valid_i) begin
      if (r_hit) begin
        pht_q[r_pidx] <= ctr_next;
        if (r_dir) btb_q[r_idx].target <= r_target_i;
      end else if (r_dir) begin
        btb_q[r_idx].valid  <= 1'b1;
        btb_q[r_idx].tag    <= r_tag;
        btb_q[r_idx].target <= r_target_i;
        pht_q[r_pidx]       <= r_is_jump_i ? CTR_MAX : CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      redirect_o    <= 1'b0;
      flush_o       <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      redirect_o    <= mispredict;
      flush_o       <= mispredict;
      redirect_pc_o <= mispredict ? actual_next : '0;
    end
  end

endmodule
